// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: control-bundle bit positions, ALUOp and funct codes,
// and the forwarding-source selection used by the ForwardingUnit.
package execute_stage_pkg;

    localparam int unsigned WB_REGWRITE  = 1;
    localparam int unsigned WB_MEMTOREG  = 0;

    localparam int unsigned MEM_BRANCH   = 2;
    localparam int unsigned MEM_MEMREAD  = 1;
    localparam int unsigned MEM_MEMWRITE = 0;

    localparam int unsigned EXE_REGDST   = 3;
    localparam int unsigned EXE_ALUOP_HI = 2;
    localparam int unsigned EXE_ALUOP_LO = 1;
    localparam int unsigned EXE_ALUSRC   = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluOp_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_e;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwdSel_e;

    // MEM stage is checked first so the youngest in-flight value wins; r0 never forwards.
    function automatic fwdSel_e pickSource(
        input logic [4:0] src,
        input logic       memRegWrite,
        input logic [4:0] memRd,
        input logic       wbRegWrite,
        input logic [4:0] wbRd
    );
        if (memRegWrite && memRd != '0 && memRd == src)
            return FWD_MEM;
        else if (wbRegWrite && wbRd != '0 && wbRd == src)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/execute_stage_forwarding.sv
// ForwardingUnit: resolves ALU operands A and B from the register file, MEM stage or WB stage.
module ForwardingUnit
    import execute_stage_pkg::*;
(
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [31:0] inRegA,
    input  logic [31:0] inRegB,
    input  logic        MEM_regwrite,
    input  logic [4:0]  MEM_rd,
    input  logic [31:0] MEM_result,
    input  logic        WB_regwrite,
    input  logic [4:0]  WB_rd,
    input  logic [31:0] WB_data,
    output logic [31:0] fwdA,
    output logic [31:0] fwdB
);

    fwdSel_e selA;
    fwdSel_e selB;

    assign selA = pickSource(in_rs, MEM_regwrite, MEM_rd, WB_regwrite, WB_rd);
    assign selB = pickSource(in_rt, MEM_regwrite, MEM_rd, WB_regwrite, WB_rd);

    always_comb begin
        fwdA = inRegA;
        case (selA)
            FWD_MEM: fwdA = MEM_result;
            FWD_WB:  fwdA = WB_data;
            default: fwdA = inRegA;
        endcase
    end

    always_comb begin
        fwdB = inRegB;
        case (selB)
            FWD_MEM: fwdB = MEM_result;
            FWD_WB:  fwdB = WB_data;
            default: fwdB = inRegB;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand forwarding, inline ALU and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  inWB,
    input  logic [2:0]  inMEM,
    input  logic [3:0]  inEXE,
    input  logic [31:0] inInstructionAddress,
    input  logic [31:0] inRegA,
    input  logic [31:0] inRegB,
    input  logic [31:0] inInstruction_ls,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  inRT_rd,
    input  logic        MEM_regwrite,
    input  logic [4:0]  MEM_rd,
    input  logic [31:0] MEM_result,
    input  logic        WB_regwrite,
    input  logic [4:0]  WB_rd,
    input  logic [31:0] WB_data,
    input  logic        inFlush,
    output logic [1:0]  outWB,
    output logic [2:0]  outMEM,
    output logic [31:0] outALUResult,
    output logic [31:0] outWriteData,
    output logic [4:0]  outRegDest,
    output logic        outZero,
    output logic        outOverflow,
    output logic [31:0] outInstructionAddress,
    output logic        EXE_mem_read,
    output logic [4:0]  EXE_rd
);

    logic [31:0] opA;
    logic [31:0] fwdB;
    logic [31:0] opB;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        addOvf;
    logic        subOvf;
    logic [4:0]  shamt;
    aluOp_e      aluOp;
    funct_e      funct;
    logic [31:0] aluResult;
    logic        overflow;

    ForwardingUnit forwarding (
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .inRegA       (inRegA),
        .inRegB       (inRegB),
        .MEM_regwrite (MEM_regwrite),
        .MEM_rd       (MEM_rd),
        .MEM_result   (MEM_result),
        .WB_regwrite  (WB_regwrite),
        .WB_rd        (WB_rd),
        .WB_data      (WB_data),
        .fwdA         (opA),
        .fwdB         (fwdB)
    );

    assign EXE_mem_read = inMEM[MEM_MEMREAD];
    assign EXE_rd       = in_rt;

    assign opB   = inEXE[EXE_ALUSRC] ? inInstruction_ls : fwdB;
    assign aluOp = aluOp_e'(inEXE[EXE_ALUOP_HI:EXE_ALUOP_LO]);
    assign funct = funct_e'(inInstruction_ls[5:0]);
    assign shamt = inInstruction_ls[10:6];

    // Signed overflow from operand/result sign bits; only reported for the trapping add/sub forms.
    assign sum    = opA + opB;
    assign diff   = opA - opB;
    assign addOvf = (opA[31] == opB[31]) && (sum[31] != opA[31]);
    assign subOvf = (opA[31] != opB[31]) && (diff[31] != opA[31]);

    always_comb begin
        aluResult = '0;
        overflow  = 1'b0;
        case (aluOp)
            ALUOP_ADD: begin aluResult = sum;  overflow = addOvf; end
            ALUOP_SUB: begin aluResult = diff; overflow = subOvf; end
            ALUOP_OR:  aluResult = opA | opB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  begin aluResult = sum;  overflow = addOvf; end
                    FN_ADDU: aluResult = sum;
                    FN_SUB:  begin aluResult = diff; overflow = subOvf; end
                    FN_SUBU: aluResult = diff;
                    FN_AND:  aluResult = opA & opB;
                    FN_OR:   aluResult = opA | opB;
                    FN_XOR:  aluResult = opA ^ opB;
                    FN_NOR:  aluResult = ~(opA | opB);
                    FN_SLT:  aluResult = {31'b0, $signed(opA) < $signed(opB)};
                    FN_SLTU: aluResult = {31'b0, opA < opB};
                    FN_SLL:  aluResult = opB << shamt;
                    FN_SRL:  aluResult = opB >> shamt;
                    FN_SRA:  aluResult = $signed(opB) >>> shamt;
                    default: aluResult = '0;
                endcase
            end
            default: aluResult = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outWB                 <= '0;
            outMEM                <= '0;
            outALUResult          <= '0;
            outWriteData          <= '0;
            outRegDest            <= '0;
            outZero               <= 1'b0;
            outOverflow           <= 1'b0;
            outInstructionAddress <= '0;
        end else begin
            outWB                 <= inFlush ? '0 : inWB;
            outMEM                <= inFlush ? '0 : inMEM;
            outALUResult          <= aluResult;
            outWriteData          <= fwdB;
            outRegDest            <= inEXE[EXE_REGDST] ? inRT_rd : in_rt;
            outZero               <= (aluResult == '0);
            outOverflow           <= overflow;
            outInstructionAddress <= inInstructionAddress;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, reset/flush sequences,
// and randomized traffic against an arithmetic reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  inWB;
    logic [2:0]  inMEM;
    logic [3:0]  inEXE;
    logic [31:0] inInstructionAddress, inRegA, inRegB, inInstruction_ls;
    logic [4:0]  in_rs, in_rt, inRT_rd;
    logic        MEM_regwrite, WB_regwrite, inFlush;
    logic [4:0]  MEM_rd, WB_rd;
    logic [31:0] MEM_result, WB_data;
    logic [1:0]  outWB;
    logic [2:0]  outMEM;
    logic [31:0] outALUResult, outWriteData, outInstructionAddress;
    logic [4:0]  outRegDest, EXE_rd;
    logic        outZero, outOverflow, EXE_mem_read;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .inWB(inWB), .inMEM(inMEM), .inEXE(inEXE),
        .inInstructionAddress(inInstructionAddress), .inRegA(inRegA), .inRegB(inRegB),
        .inInstruction_ls(inInstruction_ls), .in_rs(in_rs), .in_rt(in_rt), .inRT_rd(inRT_rd),
        .MEM_regwrite(MEM_regwrite), .MEM_rd(MEM_rd), .MEM_result(MEM_result),
        .WB_regwrite(WB_regwrite), .WB_rd(WB_rd), .WB_data(WB_data), .inFlush(inFlush),
        .outWB(outWB), .outMEM(outMEM), .outALUResult(outALUResult), .outWriteData(outWriteData),
        .outRegDest(outRegDest), .outZero(outZero), .outOverflow(outOverflow),
        .outInstructionAddress(outInstructionAddress), .EXE_mem_read(EXE_mem_read), .EXE_rd(EXE_rd)
    );

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  exe;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic        memRw;
        logic [4:0]  memRd;
        logic [31:0] memRes;
        logic        wbRw;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic        flush;
    } stim_t;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] writeData;
        logic [4:0]  regDest;
        logic [1:0]  wb;
        logic [2:0]  mem;
    } exp_t;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic stim_t mk(input logic [3:0] exe, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
        stim_t s;
        s = '{wb: 2'b00, mem: 3'b000, exe: exe, pc: 32'h0, a: a, b: b, imm: imm,
              rs: 5'd1, rt: 5'd2, rd: 5'd9, memRw: 1'b0, memRd: 5'd0, memRes: 32'h0,
              wbRw: 1'b0, wbRd: 5'd0, wbData: 32'h0, flush: 1'b0};
        return s;
    endfunction

    function automatic exp_t mkExp(input logic [31:0] result, input logic zero, input logic ovf,
                                   input logic [31:0] wd, input logic [4:0] rdest,
                                   input logic [1:0] wb, input logic [2:0] mem);
        exp_t e;
        e = '{result: result, zero: zero, ovf: ovf, writeData: wd, regDest: rdest, wb: wb, mem: mem};
        return e;
    endfunction

    // Reference model: plain arithmetic on wide signed integers, no bit-level tricks.
    function automatic logic [31:0] forwardOf(input logic [4:0] src, input logic [31:0] regVal, input stim_t s);
        if (s.memRw && s.memRd != 0 && s.memRd == src) return s.memRes;
        if (s.wbRw && s.wbRd != 0 && s.wbRd == src) return s.wbData;
        return regVal;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] a, bF, b, ones;
        longint      r;
        longint      p2;
        bit          checked;
        int unsigned op;
        a       = forwardOf(s.rs, s.a, s);
        bF      = forwardOf(s.rt, s.b, s);
        b       = s.exe[0] ? s.imm : bF;
        p2      = longint'(1) << s.imm[10:6];
        ones    = '1;
        checked = 1'b0;
        r       = 0;
        op      = 32'(s.exe[2:1]);
        if (op == 0) begin r = longint'($signed(a)) + longint'($signed(b)); checked = 1'b1; end
        else if (op == 1) begin r = longint'($signed(a)) - longint'($signed(b)); checked = 1'b1; end
        else if (op == 3) r = longint'(a | b);
        else begin
            case (s.imm[5:0])
                6'h20: begin r = longint'($signed(a)) + longint'($signed(b)); checked = 1'b1; end
                6'h21: r = longint'(a) + longint'(b);
                6'h22: begin r = longint'($signed(a)) - longint'($signed(b)); checked = 1'b1; end
                6'h23: r = longint'(a) - longint'(b);
                6'h24: r = longint'(a & b);
                6'h25: r = longint'(a | b);
                6'h26: r = longint'(a ^ b);
                6'h27: r = longint'(~(a | b));
                6'h2A: r = ($signed(a) < $signed(b)) ? 1 : 0;
                6'h2B: r = (a < b) ? 1 : 0;
                6'h00: r = longint'(b) * p2;
                6'h02: r = longint'(b) / p2;
                6'h03: r = longint'((b >> s.imm[10:6]) | (b[31] ? ~(ones >> s.imm[10:6]) : 32'h0));
                default: r = 0;
            endcase
        end
        e.result    = r[31:0];
        e.ovf       = checked && (r > 64'sd2147483647 || r < -64'sd2147483648);
        e.zero      = (e.result == 0);
        e.writeData = bF;
        e.regDest   = s.exe[3] ? s.rd : s.rt;
        e.wb        = s.flush ? 2'b00 : s.wb;
        e.mem       = s.flush ? 3'b000 : s.mem;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        inWB = s.wb; inMEM = s.mem; inEXE = s.exe; inInstructionAddress = s.pc;
        inRegA = s.a; inRegB = s.b; inInstruction_ls = s.imm;
        in_rs = s.rs; in_rt = s.rt; inRT_rd = s.rd;
        MEM_regwrite = s.memRw; MEM_rd = s.memRd; MEM_result = s.memRes;
        WB_regwrite = s.wbRw; WB_rd = s.wbRd; WB_data = s.wbData; inFlush = s.flush;
    endtask

    task automatic compareOut(input string tag, input stim_t s, input exp_t e);
        check({tag, ".wb"},        32'(outWB),        32'(e.wb));
        check({tag, ".mem"},       32'(outMEM),       32'(e.mem));
        check({tag, ".result"},    outALUResult,      e.result);
        check({tag, ".writeData"}, outWriteData,      e.writeData);
        check({tag, ".regDest"},   32'(outRegDest),   32'(e.regDest));
        check({tag, ".zero"},      32'(outZero),      32'(e.zero));
        check({tag, ".ovf"},       32'(outOverflow),  32'(e.ovf));
        check({tag, ".pc"},        outInstructionAddress, s.pc);
    endtask

    task automatic runVec(input string tag, input stim_t s, input exp_t e);
        drive(s);
        #1;
        check({tag, ".memReadComb"}, 32'(EXE_mem_read), 32'(s.mem[1]));
        check({tag, ".exeRdComb"},   32'(EXE_rd),       32'(s.rt));
        @(posedge clk);
        #1;
        compareOut(tag, s, e);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".wb"},     32'(outWB),      0);
        check({tag, ".mem"},    32'(outMEM),     0);
        check({tag, ".result"}, outALUResult,    0);
        check({tag, ".wdata"},  outWriteData,    0);
        check({tag, ".rdest"},  32'(outRegDest), 0);
        check({tag, ".zero"},   32'(outZero),    0);
        check({tag, ".ovf"},    32'(outOverflow), 0);
        check({tag, ".pc"},     outInstructionAddress, 0);
    endtask

    localparam logic [3:0] R = 4'b1100;

    stim_t vecs[$];
    exp_t  exps[$];

    initial begin
        stim_t s, sraOp;
        exp_t  e;
        int unsigned functs[14];

        // Directed table: {stimulus, hand-derived expectation}.
        s = mk(R, 5, 7, 32'h20); s.wb = 2'b11; s.mem = 3'b101;
        vecs.push_back(s); exps.push_back(mkExp(12, 0, 0, 7, 9, 2'b11, 3'b101));
        s = mk(4'b0001, 32'h55, 32'h10, 1); s.rs = 3;
        s.memRw = 1; s.memRd = 3; s.memRes = 32'hAA; s.wbRw = 1; s.wbRd = 3; s.wbData = 32'hBB;
        vecs.push_back(s); exps.push_back(mkExp(32'hAB, 0, 0, 32'h10, 2, 0, 0));
        s = mk(4'b0000, 0, 0, 0); s.rs = 0; s.rt = 0;
        s.memRw = 1; s.memRd = 0; s.memRes = 32'h99; s.wbRw = 1; s.wbRd = 0; s.wbData = 32'h77;
        vecs.push_back(s); exps.push_back(mkExp(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(R, 32'h7FFFFFFF, 1, 32'h20)); exps.push_back(mkExp(32'h80000000, 0, 1, 1, 9, 0, 0));
        vecs.push_back(mk(R, 32'h7FFFFFFF, 1, 32'h21)); exps.push_back(mkExp(32'h80000000, 0, 0, 1, 9, 0, 0));
        vecs.push_back(mk(R, 32'h80000000, 1, 32'h22)); exps.push_back(mkExp(32'h7FFFFFFF, 0, 1, 1, 9, 0, 0));
        vecs.push_back(mk(R, 32'hFFFFFFFF, 1, 32'h2A)); exps.push_back(mkExp(1, 0, 0, 1, 9, 0, 0));
        vecs.push_back(mk(R, 32'hFFFFFFFF, 1, 32'h2B)); exps.push_back(mkExp(0, 1, 0, 1, 9, 0, 0));
        vecs.push_back(mk(R, 0, 1, 32'h100));           exps.push_back(mkExp(32'h10, 0, 0, 1, 9, 0, 0));
        vecs.push_back(mk(R, 0, 32'h80000000, 32'h103)); exps.push_back(mkExp(32'hF8000000, 0, 0, 32'h80000000, 9, 0, 0));
        vecs.push_back(mk(R, 0, 32'h80000000, 32'h102)); exps.push_back(mkExp(32'h08000000, 0, 0, 32'h80000000, 9, 0, 0));
        vecs.push_back(mk(R, 3, 4, 32'h3F));            exps.push_back(mkExp(0, 1, 0, 4, 9, 0, 0));
        vecs.push_back(mk(4'b0111, 32'hF, 0, 32'hF0));  exps.push_back(mkExp(32'hFF, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(4'b0010, 5, 5, 0));           exps.push_back(mkExp(0, 1, 0, 5, 2, 0, 0));
        vecs.push_back(mk(R, 0, 0, 32'h27));            exps.push_back(mkExp(32'hFFFFFFFF, 0, 0, 0, 9, 0, 0));
        s = mk(R, 0, 1, 32'h25); s.rt = 6; s.wbRw = 1; s.wbRd = 6; s.wbData = 32'h1234;
        vecs.push_back(s); exps.push_back(mkExp(32'h1234, 0, 0, 32'h1234, 9, 0, 0));
        s = mk(R, 2, 3, 32'h24); s.wb = 2'b10; s.mem = 3'b010; s.flush = 1;
        vecs.push_back(s); exps.push_back(mkExp(2, 0, 0, 3, 9, 0, 0));
        vecs.push_back(mk(4'b0001, 32'h7FFFFFFF, 0, 1)); exps.push_back(mkExp(32'h80000000, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk(R, 32'hF0F0, 32'hFF00, 32'h26)); exps.push_back(mkExp(32'h0FF0, 0, 0, 32'hFF00, 9, 0, 0));
        vecs.push_back(mk(R, 0, 1, 32'h23));            exps.push_back(mkExp(32'hFFFFFFFF, 0, 0, 1, 9, 0, 0));

        // Reset state
        s = mk(4'b0000, 0, 0, 0);
        drive(s);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            vecs[i].pc = 32'h400 + 32'(i) * 4;
            runVec($sformatf("vec%0d", i), vecs[i], exps[i]);
        end

        // Reset mid-stream (with flush also high) discards the in-flight sra, then the op reruns cleanly.
        s = mk(R, 1, 2, 32'h20); s.wb = 2'b11; s.mem = 3'b001; s.pc = 32'h800;
        runVec("preReset", s, mkExp(3, 0, 0, 2, 9, 2'b11, 3'b001));
        sraOp = mk(R, 0, 32'h80000000, 32'h103); sraOp.wb = 2'b10; sraOp.mem = 3'b001; sraOp.pc = 32'h804;
        sraOp.flush = 1'b1;
        drive(sraOp);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("midReset");
        rst = 1'b0;
        sraOp.flush = 1'b0;
        runVec("postReset", sraOp, mkExp(32'hF8000000, 0, 0, 32'h80000000, 9, 2'b10, 3'b001));

        // Randomized traffic against the reference model.
        functs = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27,
                   32'h2A, 32'h2B, 32'h00, 32'h02, 32'h03, 32'h3D};
        for (int unsigned n = 0; n < 400; n++) begin
            s.wb     = 2'($urandom);
            s.mem    = 3'($urandom);
            s.exe    = 4'($urandom);
            s.pc     = $urandom;
            s.a      = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
            s.b      = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            s.imm    = {21'($urandom), 5'($urandom), 6'(functs[$urandom_range(0, 13)])};
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.rd     = 5'($urandom);
            s.memRw  = 1'($urandom);
            s.memRd  = 5'($urandom_range(0, 3));
            s.memRes = $urandom;
            s.wbRw   = 1'($urandom);
            s.wbRd   = 5'($urandom_range(0, 3));
            s.wbData = $urandom;
            s.flush  = ($urandom_range(0, 7) == 0);
            e = model(s);
            runVec($sformatf("rand%0d", n), s, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 The ID/EX inputs SHALL be: inWB (in, 2) [1]=RegWrite, [0]=MemtoReg; inMEM (in, 3) [2]=Branch, [1]=MemRead, [0]=MemWrite; inEXE (in, 4) [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc.
REQ-003 The remaining ID/EX inputs SHALL be: inInstructionAddress (in, 32); inRegA and inRegB (in, 32, register-file operands); inInstruction_ls (in, 32, sign-extended immediate); in_rs, in_rt and inRT_rd (in, 5 each).
REQ-004 The forwarding inputs SHALL be: MEM_regwrite (in, 1); MEM_rd (in, 5); MEM_result (in, 32); WB_regwrite (in, 1); WB_rd (in, 5); WB_data (in, 32).
REQ-005 inFlush (in, 1) SHALL zero the control fields captured into EX/MEM.
REQ-006 The EX/MEM outputs SHALL be: outWB (out, 2); outMEM (out, 3); outALUResult (out, 32); outWriteData (out, 32, forwarded B); outRegDest (out, 5); outZero (out, 1); outOverflow (out, 1); outInstructionAddress (out, 32).
REQ-007 The hazard feedback outputs SHALL be: EXE_mem_read (out, 1) = inMEM[1]; EXE_rd (out, 5) = in_rt; both combinational from the current ID/EX inputs.

Function
REQ-008 Forward A SHALL select MEM_result if MEM_regwrite && MEM_rd!=0 && MEM_rd==in_rs; else WB_data if WB_regwrite && WB_rd!=0 && WB_rd==in_rs; else inRegA.
REQ-009 Forward B SHALL use the same rule with in_rt; when both stages match, the MEM stage takes priority.
REQ-010 ALU operand 2 SHALL be inInstruction_ls when ALUSrc=1, else forwarded B; outWriteData SHALL always be forwarded B.
REQ-011 ALUOp SHALL decode as: 00=add; 01=sub; 11=or.
REQ-012 ALUOp=10 SHALL decode funct=inInstruction_ls[5:0] as: 20/21 add; 22/23 sub; 24 and; 25 or; 26 xor; 27 nor; 2A slt (signed); 2B sltu; 00 sll; 02 srl; 03 sra.
REQ-013 Shift amount SHALL be inInstruction_ls[10:6]; shifts apply to operand 2.
REQ-014 An undefined funct SHALL produce result 0.
REQ-015 All arithmetic SHALL be 32-bit with wrap-around; slt/sltu SHALL return 32'd1 or 32'd0.
REQ-016 Overflow SHALL be flagged only for funct 20/22 and ALUOp 00/01: set when the operand signs imply signed overflow; the result SHALL still be written.
REQ-017 Zero SHALL be 1 when the ALU result equals 0.
REQ-018 RegDest SHALL be inRT_rd when RegDst=1, else in_rt.
REQ-019 On each rising clk edge the block SHALL register outWB, outMEM, outALUResult, outWriteData, outRegDest, outZero, outOverflow and outInstructionAddress; latency is exactly one cycle.
REQ-020 When inFlush=1 at the edge, outWB and outMEM SHALL load 0 while the data fields load normally.
REQ-021 When rst and inFlush are asserted together, rst SHALL win.

Reset
REQ-022 When rst=1 at a rising edge, every registered output SHALL be 0, including outMEM=3'b000, and outRegDest SHALL be 0.
REQ-023 A reset asserted mid-stream SHALL discard the in-flight operation with no residual write enable.

Structure
REQ-024 The ALUOp codes, funct codes, and control bit positions of WB, MEM and EXE SHALL be constants in the shared package used by the ControlBlock.
REQ-025 Forwarding selection SHALL be a sub-module named ForwardingUnit; the ALU SHALL be inline.

Verification
REQ-026 Scenario add: ALUOp=10, funct 20, A=5, B=7, no forwarding -> next edge outALUResult=12, outZero=0.
REQ-027 Scenario double hazard: in_rs=3, MEM_rd=3 with MEM_result=0xAA, WB_rd=3 with WB_data=0xBB, ALUOp=00, ALUSrc=1, imm=1 -> outALUResult=0xAB.
REQ-028 Scenario r0 guard: MEM_rd=0, MEM_regwrite=1, in_rs=0, inRegA=0 -> no forwarding, operand A=0.
REQ-029 Scenario signed overflow: funct 20, A=0x7FFFFFFF, B=1 -> outOverflow=1, outALUResult=0x80000000; funct 21 with the same operands -> outOverflow=0.
REQ-030 Scenario flush: inWB=2'b10, inMEM=3'b010, inFlush=1 -> outWB=0, outMEM=0; EXE_mem_read=1 combinationally before the edge.
REQ-031 Scenario reset: rst pulsed during a sra of 0x80000000 by 4 -> all outputs 0 next edge; after release the same operation -> outALUResult=0xF8000000.
